// File: rtl/opfetch_pkg.sv
// Shared types and helpers for the operand-fetch front end.
package opfetch_pkg;

  typedef enum logic [0:0] {
    WAIT_BANK = 1'b0,
    RUN       = 1'b1
  } opfetch_state_e;

  localparam int REG_ZERO = 0;

  function automatic int bank_size(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/opfetch_scoreboard.sv
// Busy-bit scoreboard for pending destination writes; a set beats a clear on the same bit.
module opfetch_scoreboard
  import opfetch_pkg::*;
#(
  parameter int BANK_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  set_en,
  input  logic [BANK_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [BANK_WIDTH-1:0] clr_idx,
  input  logic [BANK_WIDTH-1:0] q1_idx,
  input  logic [BANK_WIDTH-1:0] q2_idx,
  input  logic [BANK_WIDTH-1:0] q_rd_idx,
  output logic                  q1_busy,
  output logic                  q2_busy,
  output logic                  q_rd_busy,
  output logic                  clr_busy
);

  localparam int NREG = bank_size(BANK_WIDTH);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  always_comb begin
    set_mask = set_en ? (NREG'(1) << set_idx) : '0;
    clr_mask = clr_en ? (NREG'(1) << clr_idx) : '0;
    busy_d   = (busy_q & ~clr_mask) | set_mask;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) busy_q <= '0;
    else              busy_q <= busy_d;
  end

  assign q1_busy   = busy_q[q1_idx];
  assign q2_busy   = busy_q[q2_idx];
  assign q_rd_busy = busy_q[q_rd_idx];
  assign clr_busy  = busy_q[clr_idx];

endmodule

// File: rtl/opfetch_unit.sv
// Operand fetch / writeback front end of the register bank.
// Optional same-cycle writeback forwarding: define OPFETCH_BYPASS_EN.
//
// state     | meaning
// WAIT_BANK | bank not ready; no issue, writebacks flagged as errors
// RUN       | issuing instructions and converting writebacks to bank writes
module opfetch_unit
  import opfetch_pkg::*;
#(
  parameter int BANK_WIDTH     = 5,
  parameter int REGISTER_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [BANK_WIDTH-1:0]     id_rs1,
  input  logic [BANK_WIDTH-1:0]     id_rs2,
  input  logic [BANK_WIDTH-1:0]     id_rd,
  input  logic                      id_rd_en,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [REGISTER_WIDTH-1:0] ex_rs1_data,
  output logic [REGISTER_WIDTH-1:0] ex_rs2_data,
  output logic [BANK_WIDTH-1:0]     ex_rd,
  output logic                      ex_rd_en,
  input  logic                      wb_valid,
  input  logic [BANK_WIDTH-1:0]     wb_rd,
  input  logic [REGISTER_WIDTH-1:0] wb_data,
  output logic [BANK_WIDTH-1:0]     rb_rs1_sel,
  output logic [BANK_WIDTH-1:0]     rb_rs2_sel,
  input  logic [REGISTER_WIDTH-1:0] rb_rs1_data,
  input  logic [REGISTER_WIDTH-1:0] rb_rs2_data,
  output logic [BANK_WIDTH-1:0]     rb_rd_sel,
  output logic [REGISTER_WIDTH-1:0] rb_rd_data,
  output logic                      rb_reg_w,
  input  logic                      rb_ready,
  output logic                      wb_err
);

  localparam logic [0:0] S_WAIT_BANK = WAIT_BANK;
  localparam logic [0:0] S_RUN       = RUN;

  logic [0:0] state_q;
  logic       run;
  logic       wb_act;
  logic       flush;
  logic       accept;
  logic       hazard;
  logic       rs1_fwd;
  logic       rs2_fwd;
  logic       rs1_busy;
  logic       rs2_busy;
  logic       rd_busy;
  logic       wb_busy;
  logic       set_en;

  assign run    = (state_q == S_RUN);
  assign wb_act = wb_valid & run & (|wb_rd);
  assign flush  = run & ~rb_ready;

`ifdef OPFETCH_BYPASS_EN
  assign rs1_fwd = wb_act & (wb_rd == id_rs1);
  assign rs2_fwd = wb_act & (wb_rd == id_rs2);
`else
  assign rs1_fwd = 1'b0;
  assign rs2_fwd = 1'b0;
`endif

  // A destination whose busy bit clears this cycle still blocks: only sources forward.
  assign hazard = ((|id_rs1) & rs1_busy & ~rs1_fwd)
                | ((|id_rs2) & rs2_busy & ~rs2_fwd)
                | (id_rd_en & (|id_rd) & rd_busy);

  assign id_ready = run & rb_ready & ~hazard & (~ex_valid | ex_ready);
  assign accept   = id_valid & id_ready;
  assign set_en   = accept & id_rd_en & (|id_rd);

  assign rb_rs1_sel = id_rs1;
  assign rb_rs2_sel = id_rs2;
  assign rb_rd_sel  = wb_rd;
  assign rb_rd_data = wb_data;
  assign rb_reg_w   = wb_act;

  opfetch_scoreboard #(.BANK_WIDTH(BANK_WIDTH)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .set_en    (set_en),
    .set_idx   (id_rd),
    .clr_en    (wb_act),
    .clr_idx   (wb_rd),
    .q1_idx    (id_rs1),
    .q2_idx    (id_rs2),
    .q_rd_idx  (id_rd),
    .q1_busy   (rs1_busy),
    .q2_busy   (rs2_busy),
    .q_rd_busy (rd_busy),
    .clr_busy  (wb_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT_BANK;
    end else begin
      case (state_q)
        S_WAIT_BANK: if (rb_ready)  state_q <= S_RUN;
        default:     if (!rb_ready) state_q <= S_WAIT_BANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rd       <= '0;
      ex_rd_en    <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid    <= 1'b1;
      ex_rs1_data <= !(|id_rs1) ? '0 : (rs1_fwd ? wb_data : rb_rs1_data);
      ex_rs2_data <= !(|id_rs2) ? '0 : (rs2_fwd ? wb_data : rb_rs2_data);
      ex_rd       <= id_rd;
      ex_rd_en    <= id_rd_en;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Writes to r0 are silently dropped, so they never raise the error.
  always_ff @(posedge clk) begin
    if (rst)
      wb_err <= 1'b0;
    else if (wb_valid && (|wb_rd) && (!run || !wb_busy))
      wb_err <= 1'b1;
  end

endmodule

// File: tb/tb_opfetch_unit.sv
// Directed bench for opfetch_unit with a behavioural register bank.
module tb_opfetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rd_en;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_rd_en;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rb_rs1_sel, rb_rs2_sel, rb_rd_sel;
  logic [31:0] rb_rs1_data, rb_rs2_data, rb_rd_data;
  logic        rb_reg_w;
  logic        rb_ready;
  logic        wb_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] bank [32];

  always #5 clk = ~clk;

  opfetch_unit #(.BANK_WIDTH(5), .REGISTER_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_rd_en    (id_rd_en),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .ex_rd       (ex_rd),
    .ex_rd_en    (ex_rd_en),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .rb_rs1_sel  (rb_rs1_sel),
    .rb_rs2_sel  (rb_rs2_sel),
    .rb_rs1_data (rb_rs1_data),
    .rb_rs2_data (rb_rs2_data),
    .rb_rd_sel   (rb_rd_sel),
    .rb_rd_data  (rb_rd_data),
    .rb_reg_w    (rb_reg_w),
    .rb_ready    (rb_ready),
    .wb_err      (wb_err)
  );

  // Bank model: async read, write at the clock edge; register i resets to 0x1000_0000 + i.
  assign rb_rs1_data = bank[rb_rs1_sel];
  assign rb_rs2_data = bank[rb_rs2_sel];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) bank[i] <= 32'h1000_0000 + i;
    end else if (rb_reg_w) begin
      bank[rb_rd_sel] <= rb_rd_data;
    end
  end

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic        en;
    logic        exr;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        e_rdy;
    logic        e_w;
    logic        e_xv;
    logic [31:0] e_r1, e_r2;
    logic [4:0]  e_rd;
    logic        e_en;
    logic        e_err;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(
    input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic en, input logic exr, input logic wbv, input logic [4:0] wbrd,
    input logic [31:0] wbd, input logic e_rdy, input logic e_w, input logic e_xv,
    input logic [31:0] e_r1, input logic [31:0] e_r2, input logic [4:0] e_rd,
    input logic e_en, input logic e_err);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.en = en; r.exr = exr;
    r.wbv = wbv; r.wbrd = wbrd; r.wbd = wbd;
    r.e_rdy = e_rdy; r.e_w = e_w; r.e_xv = e_xv; r.e_r1 = e_r1; r.e_r2 = e_r2;
    r.e_rd = e_rd; r.e_en = e_en; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic en);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd_en = en;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  bp_rs1 [3];
  logic [4:0]  bp_rs2 [3];
  logic [31:0] bp_e1  [3];
  logic [31:0] bp_e2  [3];

  initial begin
    // Row: inputs, then id_ready / rb_reg_w in-cycle, then registered outputs after the edge.
    tbl[0]  = mk(1, 1, 2, 3, 1, 1, 0, 0, 0,            1, 0, 1, 32'h1000_0001, 32'h1000_0002, 3, 1, 0);
    tbl[1]  = mk(1, 4, 0, 0, 1, 1, 0, 0, 0,            1, 0, 1, 32'h1000_0004, 0,             0, 1, 0);
    tbl[2]  = mk(1, 3, 1, 6, 0, 1, 0, 0, 0,            0, 0, 0, 32'h1000_0004, 0,             0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 1, 3, 32'h3333_3333, 1, 1, 0, 32'h1000_0004, 0,             0, 1, 0);
    tbl[4]  = mk(1, 3, 3, 3, 0, 1, 0, 0, 0,            1, 0, 1, 32'h3333_3333, 32'h3333_3333, 3, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0,            1, 0, 1, 0,             0,             0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 32'h0000_FFFF, 1, 0, 0, 0,             0,             0, 1, 0);
    tbl[7]  = mk(1, 2, 1, 8, 1, 1, 0, 0, 0,            1, 0, 1, 32'h1000_0002, 32'h1000_0001, 8, 1, 0);
    tbl[8]  = mk(1, 0, 0, 8, 1, 1, 0, 0, 0,            0, 0, 0, 32'h1000_0002, 32'h1000_0001, 8, 1, 0);
    tbl[9]  = mk(1, 0, 0, 8, 1, 1, 1, 8, 32'h0000_0088, 0, 1, 0, 32'h1000_0002, 32'h1000_0001, 8, 1, 0);
    tbl[10] = mk(1, 0, 0, 8, 1, 1, 0, 0, 0,            1, 0, 1, 0,             0,             8, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 1, 9, 32'h0000_0099, 1, 1, 0, 0,             0,             8, 1, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 1, 8, 32'h0000_0800, 1, 1, 0, 0,             0,             8, 1, 1);

    bp_rs1[0] = 4; bp_rs2[0] = 6; bp_e1[0] = 32'h1000_0004; bp_e2[0] = 32'h1000_0006;
    bp_rs1[1] = 1; bp_rs2[1] = 4; bp_e1[1] = 32'h1000_0001; bp_e2[1] = 32'h1000_0004;
    bp_rs1[2] = 2; bp_rs2[2] = 0; bp_e1[2] = 32'h1000_0002; bp_e2[2] = 32'h0000_0000;

    rst = 1'b1; rb_ready = 1'b0; ex_ready = 1'b1;
    set_id(0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    tick; tick;
    chk("rst_id_ready", id_ready, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_rs1", ex_rs1_data, 0);
    chk("rst_ex_rs2", ex_rs2_data, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_ex_rd_en", ex_rd_en, 0);
    chk("rst_rb_reg_w", rb_reg_w, 0);
    chk("rst_wb_err", wb_err, 0);
    rst = 1'b0;

    // Bank not ready for 33 cycles: nothing issues, a stray writeback is an error.
    for (int i = 0; i < 33; i++) begin
      set_id(1, 1, 2, 3, 1);
      set_wb(i == 10, 4, 32'h4444_4444);
      #1;
      chk("wait_id_ready", id_ready, 0);
      if (i == 10) chk("wait_wb_no_write", rb_reg_w, 0);
      tick;
    end
    set_id(0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    chk("wait_wb_err", wb_err, 1);
    chk("wait_ex_valid", ex_valid, 0);
    rb_ready = 1'b1;
    #1;
    chk("rise_same_cycle", id_ready, 0);
    tick;
    chk("rise_next_cycle", id_ready, 1);

    rst = 1'b1;
    tick;
    chk("rst_clears_err", wb_err, 0);
    rst = 1'b0;
    tick;

    for (int r = 0; r < 13; r++) begin
      set_id(tbl[r].v, tbl[r].rs1, tbl[r].rs2, tbl[r].rd, tbl[r].en);
      ex_ready = tbl[r].exr;
      set_wb(tbl[r].wbv, tbl[r].wbrd, tbl[r].wbd);
      #1;
      chk($sformatf("row%0d_id_ready", r), id_ready, tbl[r].e_rdy);
      chk($sformatf("row%0d_rb_reg_w", r), rb_reg_w, tbl[r].e_w);
      tick;
      chk($sformatf("row%0d_ex_valid", r), ex_valid, tbl[r].e_xv);
      chk($sformatf("row%0d_ex_rs1", r), ex_rs1_data, tbl[r].e_r1);
      chk($sformatf("row%0d_ex_rs2", r), ex_rs2_data, tbl[r].e_r2);
      chk($sformatf("row%0d_ex_rd", r), ex_rd, tbl[r].e_rd);
      chk($sformatf("row%0d_ex_rd_en", r), ex_rd_en, tbl[r].e_en);
      chk($sformatf("row%0d_wb_err", r), wb_err, tbl[r].e_err);
    end
    set_id(0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    chk("bank9_written", bank[9], 32'h0000_0099);

    rst = 1'b1;
    tick;
    chk("rst_err_cleared", wb_err, 0);
    rst = 1'b0;
    tick;

    // RAW on r5 resolved by a writeback.
    set_id(1, 0, 0, 5, 1);
    #1;
    chk("raw_issue_ready", id_ready, 1);
    tick;
    set_id(1, 5, 0, 0, 0);
    #1;
    chk("raw_stall", id_ready, 0);
    tick;
    set_wb(1, 5, 32'hDEAD_BEEF);
    #1;
    chk("raw_wb_write", rb_reg_w, 1);
`ifdef OPFETCH_BYPASS_EN
    chk("raw_bypass_ready", id_ready, 1);
    tick;
    set_wb(0, 0, 0);
`else
    chk("raw_wb_cycle_stall", id_ready, 0);
    tick;
    set_wb(0, 0, 0);
    #1;
    chk("raw_late_ready", id_ready, 1);
    tick;
`endif
    chk("raw_ex_valid", ex_valid, 1);
    chk("raw_ex_rs1", ex_rs1_data, 32'hDEAD_BEEF);
    chk("raw_no_err", wb_err, 0);
    set_id(0, 0, 0, 0, 0);
    tick;

    // Back-pressure: bundle held for 3 cycles, then back-to-back issue.
    ex_ready = 1'b0;
    set_id(1, 1, 2, 0, 0);
    #1;
    chk("bp_first_ready", id_ready, 1);
    tick;
    set_id(1, bp_rs1[0], bp_rs2[0], 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_ready", id_ready, 0);
      tick;
      chk("bp_hold_valid", ex_valid, 1);
      chk("bp_hold_rs1", ex_rs1_data, 32'h1000_0001);
      chk("bp_hold_rs2", ex_rs2_data, 32'h1000_0002);
    end
    ex_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, bp_rs1[i], bp_rs2[i], 0, 0);
      #1;
      chk("bp_stream_ready", id_ready, 1);
      tick;
      chk("bp_stream_valid", ex_valid, 1);
      chk("bp_stream_rs1", ex_rs1_data, bp_e1[i]);
      chk("bp_stream_rs2", ex_rs2_data, bp_e2[i]);
    end
    set_id(0, 0, 0, 0, 0);
    tick;

    // Bank drops ready: bundle discarded and scoreboard flushed.
    set_id(1, 0, 0, 10, 1);
    tick;
    set_id(0, 0, 0, 0, 0);
    ex_ready = 1'b0;
    rb_ready = 1'b0;
    #1;
    chk("flush_id_ready", id_ready, 0);
    tick;
    chk("flush_ex_valid", ex_valid, 0);
    rb_ready = 1'b1;
    tick;
    set_id(1, 10, 0, 0, 0);
    #1;
    chk("flush_busy_cleared", id_ready, 1);
    tick;
    set_id(0, 0, 0, 0, 0);
    chk("flush_reissue_rs1", ex_rs1_data, 32'h1000_000A);

    // Reset mid-operation discards a held bundle.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_ex_valid", ex_valid, 0);
    chk("midrst_ex_rs1", ex_rs1_data, 0);
    ex_ready = 1'b1;
    tick;

    // Set and clear of r7 in one cycle: set wins, stray writeback flagged.
    set_id(1, 0, 0, 7, 1);
    set_wb(1, 7, 32'h0000_0077);
    #1;
    chk("sw_ready", id_ready, 1);
    chk("sw_write", rb_reg_w, 1);
    tick;
    set_wb(0, 0, 0);
    chk("sw_err", wb_err, 1);
    set_id(1, 7, 0, 0, 0);
    #1;
    chk("sw_busy_kept", id_ready, 0);
    tick;
    set_id(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
